// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame transmitter and the detector bench.
package serial_frame_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_GAP_CYCLES = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } tx_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial word shifter with bit-enable pacing, optional idle gap and per-word done pulse.
module serial_frame_transmitter
    import serial_frame_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic             data_serial,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int GCW = cnt_width(GAP_CYCLES + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    tx_state_t        state_q,   state_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             head_s;

    assign head_s = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        data_in_ready = 1'b0;
        data_serial   = 1'b0;
        data_valid    = 1'b0;
        busy          = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_in_ready = 1'b1;
                if (data_in_valid) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                busy        = 1'b1;
                data_serial = head_s;
                data_valid  = bit_en;
                if (bit_en) begin
                    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shift_q[WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        frame_done = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (bit_en) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GCW'(1);
                    end
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    // State, shift register and counters; reset discards any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Two transmitter instances (MSB-first/no gap, LSB-first/gap 2) checked against a bit-queue reference model.
module tb_serial_frame_transmitter;

    logic clk;
    int   checks;
    int   errors;

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit MSB = (g == 0);
        localparam int GAP = (g == 0) ? 0 : 2;

        logic       rst_n_s;
        logic       bit_en_s;
        logic [7:0] din_s;
        logic       vin_s;
        logic       rdy_s;
        logic       ser_s;
        logic       dv_s;
        logic       busy_s;
        logic       fd_s;
        int         en_mode;
        int         en_cnt;
        int         gap_left;
        bit         exp_q[$];
        bit         done_f;

        serial_frame_transmitter #(
            .WIDTH(8), .MSB_FIRST(MSB), .GAP_CYCLES(GAP)
        ) u_dut (
            .clk(clk), .reset_n(rst_n_s), .bit_en(bit_en_s),
            .data_in(din_s), .data_in_valid(vin_s), .data_in_ready(rdy_s),
            .data_serial(ser_s), .data_valid(dv_s), .busy(busy_s), .frame_done(fd_s)
        );

        // Expected serial bit order for one word, computed directly from the word.
        task automatic push_word(input logic [7:0] w);
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(MSB ? w[7-i] : w[i]);
            end
        endtask

        task automatic send(input logic [7:0] w);
            int n;
            n     = 0;
            din_s = w;
            vin_s = 1'b1;
            do begin
                @(negedge clk);
                n++;
            end while (!rdy_s && n < 400);
            chk($sformatf("L%0d accept timeout", g), 32'(n < 400), 32'd1);
            @(posedge clk);
            if (n < 400) push_word(w);
            #1 vin_s = 1'b0;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(exp_q.size() == 0 && gap_left == 0 && rdy_s) && n < 1000);
            chk($sformatf("L%0d idle reached", g), 32'(n < 1000), 32'd1);
            @(posedge clk);
            #1;
        endtask

        // Bit-enable pattern generator: tied high, every third cycle, or random.
        initial begin
            bit_en_s = 1'b0;
            en_cnt   = 0;
            forever begin
                @(posedge clk);
                #1;
                case (en_mode)
                    1: begin
                        en_cnt   = (en_cnt + 1) % 3;
                        bit_en_s = (en_cnt == 0);
                    end
                    2:       bit_en_s = 1'($urandom_range(0, 1));
                    default: bit_en_s = 1'b1;
                endcase
            end
        end

        // Monitor: compares every cycle against the frame queue and gap tick budget.
        initial begin
            gap_left = 0;
            forever begin
                @(negedge clk);
                if (!rst_n_s) begin
                    exp_q.delete();
                    gap_left = 0;
                    chk($sformatf("L%0d rst ready", g), 32'(rdy_s), 32'd1);
                    chk($sformatf("L%0d rst serial", g), 32'(ser_s), 32'd0);
                    chk($sformatf("L%0d rst valid", g), 32'(dv_s), 32'd0);
                    chk($sformatf("L%0d rst busy", g), 32'(busy_s), 32'd0);
                    chk($sformatf("L%0d rst frame_done", g), 32'(fd_s), 32'd0);
                end else if (exp_q.size() > 0) begin
                    chk($sformatf("L%0d shift busy", g), 32'(busy_s), 32'd1);
                    chk($sformatf("L%0d shift ready", g), 32'(rdy_s), 32'd0);
                    chk($sformatf("L%0d shift serial", g), 32'(ser_s), 32'(exp_q[0]));
                    chk($sformatf("L%0d shift valid", g), 32'(dv_s), 32'(bit_en_s));
                    chk($sformatf("L%0d frame_done", g), 32'(fd_s),
                        32'(bit_en_s && exp_q.size() == 1));
                    if (bit_en_s) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) gap_left = GAP;
                    end
                end else if (gap_left > 0) begin
                    chk($sformatf("L%0d gap busy", g), 32'(busy_s), 32'd1);
                    chk($sformatf("L%0d gap ready", g), 32'(rdy_s), 32'd0);
                    chk($sformatf("L%0d gap valid", g), 32'(dv_s), 32'd0);
                    chk($sformatf("L%0d gap serial", g), 32'(ser_s), 32'd0);
                    chk($sformatf("L%0d gap frame_done", g), 32'(fd_s), 32'd0);
                    if (bit_en_s) gap_left--;
                end else begin
                    chk($sformatf("L%0d idle ready", g), 32'(rdy_s), 32'd1);
                    chk($sformatf("L%0d idle busy", g), 32'(busy_s), 32'd0);
                    chk($sformatf("L%0d idle valid", g), 32'(dv_s), 32'd0);
                    chk($sformatf("L%0d idle serial", g), 32'(ser_s), 32'd0);
                    chk($sformatf("L%0d idle frame_done", g), 32'(fd_s), 32'd0);
                end
            end
        end

        // Directed scenarios followed by randomized words and bit-enable.
        initial begin
            done_f  = 1'b0;
            en_mode = 0;
            vin_s   = 1'b0;
            din_s   = 8'h00;
            rst_n_s = 1'b1;
            #1 rst_n_s = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n_s = 1'b1;

            send(8'hB4);
            wait_idle();

            en_mode = 1;
            send(8'h01);
            wait_idle();

            en_mode = 0;
            send(8'hFF);
            send(8'h00);
            wait_idle();

            send(8'h24);
            wait_idle();

            send(8'hA5);
            repeat (4) @(posedge clk);
            #1 rst_n_s = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n_s = 1'b1;
            send(8'h3C);
            wait_idle();

            en_mode = 2;
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(8'($urandom));
            end
            wait_idle();
            done_f = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(lane[0].done_f && lane[1].done_f) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        chk("lanes finished", 32'(lane[0].done_f && lane[1].done_f), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
